// File: rtl/e1ofn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | e1ofn_pkg : shared types and helpers for the e1ofN channel bridges         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package e1ofn_pkg;

    localparam int RADIX = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RTZ  = 2'd2
    } e1ofn_tx_state_t;

    function automatic logic [RADIX-1:0] enc_1of4(input logic [1:0] v);
        return 4'b0001 << v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/e1ofn_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | e1ofn_sync : reset-to-0 flop chain for bringing an async level into clk    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module e1ofn_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/e1ofn_tx_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | e1ofn_tx_bridge : valid/ready words -> 1-of-4 rails on a 4-phase e1ofN link |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module e1ofn_tx_bridge
    import e1ofn_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int FIFO_DEPTH  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2*NUM_DIGITS-1:0]   in_data_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic [4*NUM_DIGITS-1:0]   ch_rail_o,
    input  logic                      ch_enable_i,
    output logic [15:0]               tx_count_o,
    output logic                      busy_o
);

    localparam int DW    = 2 * NUM_DIGITS;
    localparam int RW    = RADIX * NUM_DIGITS;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic                  en_s;
    logic                  push;
    logic                  pop;
    logic [DW-1:0]         fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  in_ready_q;
    logic [DW-1:0]         head_word;
    logic [RW-1:0]         enc_word;
    e1ofn_tx_state_t       state_q;
    e1ofn_tx_state_t       state_d;
    logic [RW-1:0]         rail_q;
    logic [RW-1:0]         rail_d;
    logic [15:0]           tx_count_q;
    logic [15:0]           tx_count_d;

    e1ofn_sync #(
        .STAGES (SYNC_STAGES)
    ) u_en_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (ch_enable_i),
        .sync_o  (en_s)
    );

    assign push    = in_valid_i & in_ready_q;
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // in_ready is a flop of "not full next cycle", so pop never reaches it combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            in_ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= in_data_i;
    end

    assign head_word = fifo_mem_q[rd_ptr_q];

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_enc
        assign enc_word[RADIX*k +: RADIX] = enc_1of4(head_word[2*k +: 2]);
    end

    always_comb begin
        state_d    = state_q;
        rail_d     = rail_q;
        tx_count_d = tx_count_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                rail_d = '0;
                if (en_s && (count_q != '0)) begin
                    pop     = 1'b1;
                    rail_d  = enc_word;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!en_s) begin
                    rail_d  = '0;
                    state_d = RTZ;
                end
            end
            RTZ: begin
                if (en_s) begin
                    tx_count_d = tx_count_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: begin
                rail_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rail_q     <= '0;
            tx_count_q <= '0;
        end else begin
            state_q    <= state_d;
            rail_q     <= rail_d;
            tx_count_q <= tx_count_d;
        end
    end

    assign in_ready_o = in_ready_q;
    assign ch_rail_o  = rail_q;
    assign tx_count_o = tx_count_q;
    assign busy_o     = (state_q != IDLE) || (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_e1ofn_tx_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_e1ofn_tx_bridge : self-checking bench with a behavioural 4-phase receiver|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_e1ofn_tx_bridge;

    localparam int NUM_DIGITS = 2;
    localparam int DW         = 2 * NUM_DIGITS;
    localparam int RW         = 4 * NUM_DIGITS;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          in_valid  = 1'b0;
    logic          ch_enable = 1'b1;
    logic          in_ready;
    logic [RW-1:0] ch_rail;
    logic [15:0]   tx_count;
    logic          busy;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [15:0]   exp_cnt = '0;
    logic [DW-1:0] model_q [$];

    typedef struct {
        logic [DW-1:0] word;
        logic [RW-1:0] rails;
    } vec_t;
    vec_t vecs [7];

    e1ofn_tx_bridge #(
        .NUM_DIGITS  (NUM_DIGITS),
        .FIFO_DEPTH  (2),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .ch_rail_o   (ch_rail),
        .ch_enable_i (ch_enable),
        .tx_count_o  (tx_count),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Decode rails digit by digit: returns {all digits exactly one-hot, word}
    function automatic logic [DW:0] decode_rails(input logic [RW-1:0] r);
        logic [DW-1:0] w;
        logic          ok;
        int            hits;
        w  = '0;
        ok = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            hits = 0;
            for (int b = 0; b < 4; b++) begin
                if (r[4*d+b]) begin
                    hits++;
                    w = w + DW'(b << (2*d));
                end
            end
            if (hits != 1) ok = 1'b0;
        end
        return {ok, w};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rails(input bit nz, input int limit, input string name);
        int i = 0;
        while (((ch_rail != '0) != nz) && (i < limit)) begin
            step();
            i++;
        end
        check({name, " rails wait"}, 32'((ch_rail != '0) == nz), 32'd1);
    endtask

    task automatic wait_count(input int limit, input string name);
        int i = 0;
        while ((tx_count != exp_cnt) && (i < limit)) begin
            step();
            i++;
        end
        check({name, " tx_count"}, 32'(tx_count), 32'(exp_cnt));
    endtask

    task automatic push_word(input logic [DW-1:0] w, input string name);
        int i = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && (i < 400)) begin
            step();
            i++;
        end
        check({name, " accepted"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic complete_word(input string name, input logic [RW-1:0] exp_r, input int dly);
        wait_rails(1'b1, 50, name);
        check({name, " code"}, 32'(ch_rail), 32'(exp_r));
        step(dly);
        ch_enable = 1'b0;
        wait_rails(1'b0, 50, name);
        step(dly);
        exp_cnt++;
        ch_enable = 1'b1;
        wait_count(50, name);
    endtask

    task automatic recv_word(input string name);
        logic [DW:0]   dec;
        logic [DW-1:0] e;
        wait_rails(1'b1, 400, name);
        dec = decode_rails(ch_rail);
        check({name, " model has word"}, 32'(model_q.size() != 0), 32'd1);
        e = (model_q.size() != 0) ? model_q.pop_front() : ~dec[DW-1:0];
        check({name, " one-hot"}, 32'(dec[DW]), 32'd1);
        check({name, " order"}, 32'(dec[DW-1:0]), 32'(e));
        step(int'($urandom_range(1, 10)));
        ch_enable = 1'b0;
        wait_rails(1'b0, 40, name);
        step(int'($urandom_range(1, 10)));
        exp_cnt++;
        ch_enable = 1'b1;
    endtask

    task automatic run_stream(input bit rnd, input int n, input string name);
        fork
            begin
                logic [DW-1:0] w;
                for (int i = 0; i < n; i++) begin
                    w = rnd ? DW'($urandom_range(0, 15)) : DW'(i);
                    if (rnd) step(int'($urandom_range(0, 2)));
                    push_word(w, name);
                    model_q.push_back(w);
                end
            end
            begin
                for (int j = 0; j < n; j++) recv_word(name);
            end
        join
        wait_count(50, name);
    endtask

    task automatic do_reset();
        ch_enable = 1'b1;
        in_valid  = 1'b0;
        rst_n     = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);
        exp_cnt = '0;
        model_q.delete();
    endtask

    always @(negedge clk) begin : onehot_mon
        logic [DW:0] dec;
        if (rst_n) begin
            dec = decode_rails(ch_rail);
            n_tests++;
            if ((ch_rail != '0) && !dec[DW]) begin
                n_fail++;
                $display("FAIL onehot: rails 0x%0h, expected one-hot per digit or neutral", ch_rail);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stalled;
        int k;

        vecs[0] = '{4'h0, 8'h11};
        vecs[1] = '{4'h9, 8'h42};
        vecs[2] = '{4'hA, 8'h44};
        vecs[3] = '{4'hF, 8'h88};
        vecs[4] = '{4'h6, 8'h24};
        vecs[5] = '{4'h3, 8'h18};
        vecs[6] = '{4'hC, 8'h81};

        // power-on reset
        step(2);
        check("reset rails",    32'(ch_rail),  32'h0);
        check("reset in_ready", 32'(in_ready), 32'h0);
        check("reset tx_count", 32'(tx_count), 32'h0);
        check("reset busy",     32'(busy),     32'h0);
        rst_n = 1'b1;
        check("ready before first edge", 32'(in_ready), 32'h0);
        step();
        check("ready after first edge", 32'(in_ready), 32'h1);
        step(3);

        // T2: single word, exact latency, 3-cycle receiver
        in_data  = 4'b1001;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("T2 rails at push edge", 32'(ch_rail), 32'h0);
        check("T2 busy with queued word", 32'(busy), 32'h1);
        step();
        check("T2 rails one edge later", 32'(ch_rail), 32'h42);
        step(3);
        ch_enable = 1'b0;
        step(2);
        check("T2 hold until en_s low", 32'(ch_rail), 32'h42);
        step();
        check("T2 neutral", 32'(ch_rail), 32'h0);
        step(3);
        ch_enable = 1'b1;
        step(2);
        check("T2 count before en_s high", 32'(tx_count), 32'h0);
        step();
        check("T2 count", 32'(tx_count), 32'h1);
        check("T2 busy", 32'(busy), 32'h0);
        exp_cnt = 16'd1;

        // encoding table
        for (int i = 0; i < 7; i++) begin
            push_word(vecs[i].word, $sformatf("vec%0d", i));
            complete_word($sformatf("vec%0d", i), vecs[i].rails, 1 + (i % 3));
        end

        // T1: reset in the middle of SEND
        push_word(4'b1001, "T1");
        wait_rails(1'b1, 20, "T1");
        check("T1 rails before reset", 32'(ch_rail), 32'h42);
        #1;
        rst_n = 1'b0;
        #1;
        check("T1 rails async", 32'(ch_rail),  32'h0);
        check("T1 tx_count",    32'(tx_count), 32'h0);
        check("T1 in_ready",    32'(in_ready), 32'h0);
        check("T1 busy",        32'(busy),     32'h0);
        step();
        rst_n = 1'b1;
        check("T1 ready before edge", 32'(in_ready), 32'h0);
        step();
        check("T1 ready after edge", 32'(in_ready), 32'h1);
        exp_cnt = '0;
        model_q.delete();
        step(4);
        check("T1 word discarded", 32'(ch_rail), 32'h0);
        check("T1 idle", 32'(busy), 32'h0);

        // T3: receiver never acknowledges
        push_word(4'h1, "T3 w1");
        push_word(4'h2, "T3 w2");
        push_word(4'h3, "T3 w3");
        check("T3 full", 32'(in_ready), 32'h0);
        check("T3 rails w1", 32'(ch_rail), 32'h12);
        check("T3 busy", 32'(busy), 32'h1);
        in_data  = 4'h4;
        in_valid = 1'b1;
        stalled  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (in_ready) stalled = 1'b0;
            step();
        end
        check("T3 4th word held off", 32'(stalled), 32'h1);
        check("T3 rails still w1", 32'(ch_rail), 32'h12);
        complete_word("T3 w1", 8'h12, 2);
        k = 0;
        while (!in_ready && (k < 20)) begin
            step();
            k++;
        end
        check("T3 4th accepted", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        complete_word("T3 w2", 8'h14, 1);
        complete_word("T3 w3", 8'h18, 2);
        complete_word("T3 w4", 8'h21, 1);
        check("T3 drained", 32'(busy), 32'h0);

        // T5: slow receiver holding enable low at idle
        ch_enable = 1'b0;
        step(4);
        push_word(4'hA, "T5");
        stalled = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (ch_rail != '0) stalled = 1'b0;
            step();
        end
        check("T5 rails stay neutral", 32'(stalled), 32'h1);
        check("T5 busy", 32'(busy), 32'h1);
        ch_enable = 1'b1;
        step(2);
        check("T5 rails after 2 edges", 32'(ch_rail), 32'h0);
        step();
        check("T5 rails after 3 edges", 32'(ch_rail), 32'h44);
        complete_word("T5", 8'h44, 1);

        // T4: ordered stream, then random words
        do_reset();
        run_stream(1'b0, 16, "T4");
        check("T4 total", 32'(tx_count), 32'd16);
        run_stream(1'b1, 24, "RND");

        // T6: counter wrap
        step(3);
        force dut.tx_count_q = 16'hFFFF;
        step();
        release dut.tx_count_q;
        exp_cnt = 16'hFFFF;
        check("T6 preload", 32'(tx_count), 32'hFFFF);
        push_word(4'h5, "T6");
        complete_word("T6", 8'h22, 1);
        check("T6 wrapped", 32'(tx_count), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
